sdram_pattern_tester: RTL and testbench
=======================================

// Module: sdram_pattern_tester
// PURPOSE
//  Parametrised SDRAM write/read-back tester driving the sdram_top user FIFO ports. Successor to the fixed
//  incrementing-data tester: adds selectable patterns, loop control, error counting and first-fail capture.
//  Sits between the board top and sdram_top; status goes to led_disp and debug taps.
// PARAMETERS
//  DW         16       data width, 8..32
//  TEST_LEN   24'h400000  words per pass; word index k = 0..TEST_LEN-1
//  GAP_CYC    1024     idle cycles between write and read pass (lets write FIFO drain to SDRAM)
//  RD_LAT     1        cycles from rd_en to valid rd_data, 1..4
//  LOOPS      0        passes per run; 0 = run forever
//  CNT_W      4        width of pass_cnt (wraps modulo 2^CNT_W)
//  SEED       32'hACE1_0001  LFSR seed, must be non-zero
// PORTS
//  clk_50m          in   1      sole clock
//  rst_n            in   1      async active-low reset
//  sdram_init_done  in   1      controller init complete
//  start            in   1      1-cycle pulse starts a run (ignored while busy)
//  mode             in   2      0 incr k, 1 ~k, 2 walking-one (1<<(k%DW)), 3 LFSR; latched each pass start
//  wr_ready         in   1      write FIFO can accept (tie 1 if unused)
//  rd_ready         in   1      read FIFO holds data (tie 1 if unused)
//  wr_en / wr_data  out  1 / DW write FIFO port
//  rd_en            out  1      read FIFO pop
//  rd_data          in   DW     read FIFO data
//  busy / done      out  1 / 1  run active / 1-cycle pulse at run end
//  error_flag       out  1      sticky, any mismatch this run
//  err_count        out  16     saturating mismatch count
//  first_err_addr   out  24     k of first mismatch
//  first_err_exp    out  DW     expected word at first mismatch
//  first_err_got    out  DW     read word at first mismatch
//  pass_cnt         out  CNT_W  completed passes
// BEHAVIOUR
//  Reset: all outputs 0; FSM IDLE; LFSR = SEED. Async reset mid-run aborts instantly, no done.
//  FSM: IDLE -start&init_done-> WRITE -k==TEST_LEN-1 written-> GAP -GAP_CYC elapsed-> READ
//   -last rd_en issued-> DRAIN -RD_LAT cycles-> NEXT; NEXT: pass_cnt++, then IDLE+done if
//   LOOPS!=0 && passes==LOOPS, else WRITE. busy=1 in all states except IDLE.
//  start: clears error_flag, err_count, first_err_*, pass_cnt one cycle before WRITE.
//  WRITE: wr_en = wr_ready; k advances only on wr_en; wr_data = pattern(k), combinational from k.
//  READ: rd_en = rd_ready; expected word and k pipelined RD_LAT stages alongside rd_en; compare when
//   delayed valid=1. Mismatch: error_flag<=1, err_count+1 (holds at 16'hFFFF), first_err_* latched
//   only when err_count==0.
//  LFSR: 32-bit Galois, taps x^32+x^22+x^2+x+1, shifts once per accepted word, data = lfsr[DW-1:0];
//   reloaded to SEED at start of each WRITE and READ pass so both passes see identical sequences.
//  Walking-one uses k%DW; incr/~k use k truncated to DW bits.
//  sdram_init_done falling while busy: abort to IDLE, wr_en/rd_en drop same cycle, no done,
//   status outputs retained.
//  start while busy: ignored. start with init_done=0: ignored.
//  wr_ready/rd_ready low: enables low, counters and LFSR hold; pipeline still drains.
// CONFIGURATION
//  SDRAM_TEST_ERR_INJECT_EN defined: adds input inj_err; a pulse during WRITE flips bit 0 of the next
//   accepted word (one word per pulse, pulses outside WRITE dropped). Undefined: port absent,
//   data never altered.
// TESTING
//  Bench models sdram_top FIFOs with ideal memory; DW=16, TEST_LEN=64, GAP_CYC=8, LOOPS=2.
//  mode=0, start -> 64 writes 0..63, 64 reads, 2 passes, done pulse, pass_cnt=2, err_count=0.
//  mode=3, SEED=1 -> written words equal reference LFSR model; read matches; error_flag=0.
//  Memory model corrupts word k=5 to 16'hDEAD in mode=0 -> err_count=2 (both passes),
//   first_err_addr=5, exp=16'h0005, got=16'hDEAD.
//  wr_ready/rd_ready randomly low 50% -> identical data sequence, no dropped/duplicated words.
//  init_done deasserted mid-READ -> rd_en low same cycle, busy=0, no done; next start runs clean.
//  With SDRAM_TEST_ERR_INJECT_EN: inj_err pulse at k=10, mode=2 -> first_err_addr=10,
//   exp=16'h0400, got=16'h0401.

Source files
------------

// File: rtl/sdram_pattern_tester.sv
// SDRAM write/read-back pattern tester driving the sdram_top user FIFO ports.
// Optional `SDRAM_TEST_ERR_INJECT_EN adds inj_err to flip bit 0 of the next accepted write word.
module sdram_pattern_tester #(
   parameter int          DW       = 16,
   parameter logic [23:0] TEST_LEN = 24'h400000,
   parameter int          GAP_CYC  = 1024,
   parameter int          RD_LAT   = 1,
   parameter int          LOOPS    = 0,
   parameter int          CNT_W    = 4,
   parameter logic [31:0] SEED     = 32'hACE1_0001
) (
   input  logic             clk_50m,
   input  logic             rst_n,
   input  logic             sdram_init_done,
   input  logic             start,
   input  logic [1:0]       mode,
   input  logic             wr_ready,
   input  logic             rd_ready,
   output logic             wr_en,
   output logic [DW-1:0]    wr_data,
   output logic             rd_en,
   input  logic [DW-1:0]    rd_data,
   output logic             busy,
   output logic             done,
   output logic             error_flag,
   output logic [15:0]      err_count,
   output logic [23:0]      first_err_addr,
   output logic [DW-1:0]    first_err_exp,
   output logic [DW-1:0]    first_err_got,
   output logic [CNT_W-1:0] pass_cnt
`ifdef SDRAM_TEST_ERR_INJECT_EN
   ,
   input  logic             inj_err
`endif
);

   typedef enum logic [2:0] {IDLE, WRITE, GAP, READ, DRAIN, NEXT} state_t;

   // Galois form of x^32+x^22+x^2+x+1, shifting right.
   localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

   state_t        state;
   logic [23:0]   k;
   logic [31:0]   lfsr;
   logic [31:0]   lfsr_next;
   logic [1:0]    mode_q;
   logic [31:0]   loop_cnt;
   logic [31:0]   gap_cnt;
   logic [2:0]    drain_cnt;
   logic [DW-1:0] pattern;
   logic [DW-1:0] k_dw;
   logic [DW-1:0] walk;
   logic          mismatch;

   logic [RD_LAT-1:0] vld_pipe;
   logic [DW-1:0]     exp_pipe [RD_LAT];
   logic [23:0]       k_pipe   [RD_LAT];

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      k_dw      = DW'(k);
      walk      = {{(DW-1){1'b0}}, 1'b1} << (k % 24'(DW));
      lfsr_next = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? LFSR_MASK : 32'h0);
      pattern   = k_dw;
      case (mode_q)
         2'd0:    pattern = k_dw;
         2'd1:    pattern = ~k_dw;
         2'd2:    pattern = walk;
         default: pattern = lfsr[DW-1:0];
      endcase
   end

   // Enables are gated by init_done combinationally so an abort drops them the same cycle.
   assign wr_en    = (state == WRITE) && wr_ready && sdram_init_done;
   assign rd_en    = (state == READ)  && rd_ready && sdram_init_done;
   assign mismatch = vld_pipe[RD_LAT-1] && (rd_data != exp_pipe[RD_LAT-1]);

`ifdef SDRAM_TEST_ERR_INJECT_EN
   logic inj_pend;

   assign wr_data = pattern ^ {{(DW-1){1'b0}}, inj_pend};

   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n)                inj_pend <= 1'b0;
      else if (state != WRITE)   inj_pend <= 1'b0;
      else if (inj_err)          inj_pend <= 1'b1;
      else if (wr_en)            inj_pend <= 1'b0;
   end
`else
   assign wr_data = pattern;
`endif

   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe <= '0;
      end else begin
         vld_pipe[0] <= rd_en;
         for (int i = 1; i < RD_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
      end
   end

   // NOTE: the expected-word/index stages carry no reset; they are only looked at when vld_pipe says so.
   always_ff @(posedge clk_50m) begin
      exp_pipe[0] <= pattern;
      k_pipe[0]   <= k;
      for (int i = 1; i < RD_LAT; i++) begin
         exp_pipe[i] <= exp_pipe[i-1];
         k_pipe[i]   <= k_pipe[i-1];
      end
   end

   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         k              <= '0;
         lfsr           <= SEED;
         mode_q         <= '0;
         loop_cnt       <= '0;
         gap_cnt        <= '0;
         drain_cnt      <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         error_flag     <= 1'b0;
         err_count      <= '0;
         first_err_addr <= '0;
         first_err_exp  <= '0;
         first_err_got  <= '0;
         pass_cnt       <= '0;
      end else begin
         done <= 1'b0;
         if (mismatch) begin
            error_flag <= 1'b1;
            if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
            if (err_count == 16'd0) begin
               first_err_addr <= k_pipe[RD_LAT-1];
               first_err_exp  <= exp_pipe[RD_LAT-1];
               first_err_got  <= rd_data;
            end
         end
         if (state != IDLE && !sdram_init_done) begin
            state <= IDLE;
            busy  <= 1'b0;
         end else begin
            case (state)
               IDLE: if (start && sdram_init_done) begin
                  error_flag     <= 1'b0;
                  err_count      <= '0;
                  first_err_addr <= '0;
                  first_err_exp  <= '0;
                  first_err_got  <= '0;
                  pass_cnt       <= '0;
                  loop_cnt       <= '0;
                  k              <= '0;
                  lfsr           <= SEED;
                  mode_q         <= mode;
                  busy           <= 1'b1;
                  state          <= WRITE;
               end
               WRITE: if (wr_en) begin
                  lfsr <= lfsr_next;
                  if (k == TEST_LEN - 24'd1) begin
                     k       <= '0;
                     gap_cnt <= '0;
                     state   <= GAP;
                  end else begin
                     k <= k + 24'd1;
                  end
               end
               GAP: if (gap_cnt == 32'(GAP_CYC - 1)) begin
                  lfsr  <= SEED;
                  k     <= '0;
                  state <= READ;
               end else begin
                  gap_cnt <= gap_cnt + 32'd1;
               end
               READ: if (rd_en) begin
                  lfsr <= lfsr_next;
                  if (k == TEST_LEN - 24'd1) begin
                     drain_cnt <= '0;
                     state     <= DRAIN;
                  end else begin
                     k <= k + 24'd1;
                  end
               end
               DRAIN: if (drain_cnt == 3'(RD_LAT - 1)) state <= NEXT;
                      else drain_cnt <= drain_cnt + 3'd1;
               NEXT: begin
                  pass_cnt <= pass_cnt + 1'b1;
                  loop_cnt <= loop_cnt + 32'd1;
                  if (LOOPS != 0 && loop_cnt + 32'd1 == 32'(LOOPS)) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= IDLE;
                  end else begin
                     k      <= '0;
                     lfsr   <= SEED;
                     mode_q <= mode;
                     state  <= WRITE;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sdram_pattern_tester.sv
// Directed bench for sdram_pattern_tester: ideal-memory FIFO model, corruption, abort, ready throttling.
// Exercises inj_err as well when built with `SDRAM_TEST_ERR_INJECT_EN.
module tb_sdram_pattern_tester;
   localparam int DW = 16;
   localparam int TL = 64;

   logic          clk_50m = 1'b0;
   logic          rst_n, sdram_init_done, start, wr_ready, rd_ready;
   logic [1:0]    mode;
   logic          wr_en, rd_en, busy, done, error_flag;
   logic [DW-1:0] wr_data, rd_data, first_err_exp, first_err_got;
   logic [15:0]   err_count;
   logic [23:0]   first_err_addr;
   logic [3:0]    pass_cnt;
`ifdef SDRAM_TEST_ERR_INJECT_EN
   logic          inj_err = 1'b0;
`endif

   always #5 clk_50m = ~clk_50m;

   sdram_pattern_tester #(
      .DW(DW), .TEST_LEN(24'(TL)), .GAP_CYC(8), .RD_LAT(1), .LOOPS(2), .CNT_W(4), .SEED(32'h1)
   ) dut (
      .clk_50m(clk_50m), .rst_n(rst_n), .sdram_init_done(sdram_init_done), .start(start),
      .mode(mode), .wr_ready(wr_ready), .rd_ready(rd_ready), .wr_en(wr_en), .wr_data(wr_data),
      .rd_en(rd_en), .rd_data(rd_data), .busy(busy), .done(done), .error_flag(error_flag),
      .err_count(err_count), .first_err_addr(first_err_addr), .first_err_exp(first_err_exp),
      .first_err_got(first_err_got), .pass_cnt(pass_cnt)
`ifdef SDRAM_TEST_ERR_INJECT_EN
      , .inj_err(inj_err)
`endif
   );

   int n_chk = 0, n_pass = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Ideal-memory FIFO model and reference pattern generator
   logic [15:0] mem  [TL];
   logic [15:0] wlog [TL];
   logic [31:0] lfsr_tab [TL];
   logic [1:0]  tb_mode = 2'd0;
   logic [15:0] wexp;
   int  wptr = 0, rptr = 0, wr_cnt = 0, rd_cnt = 0, wr_bad = 0, done_cnt = 0, inj_k = -1;
   bit  corrupt = 0, rand_rdy = 0, rd_pend = 0;

   function automatic logic [15:0] model_word(input logic [1:0] m, input int idx);
      case (m)
         2'd0:    return 16'(idx);
         2'd1:    return ~16'(idx);
         2'd2:    return 16'h1 << (idx % 16);
         default: return lfsr_tab[idx][15:0];
      endcase
   endfunction

   always @(negedge clk_50m) begin
      if (wr_en === 1'b1) begin
         wexp = model_word(tb_mode, wptr);
         if (wptr == inj_k && wr_cnt < TL) wexp[0] = ~wexp[0];
         if (wr_data !== wexp) wr_bad++;
         wlog[wptr] = wr_data;
         mem[wptr]  = (corrupt && wptr == 5) ? 16'hDEAD : wr_data;
         wptr       = (wptr + 1) % TL;
         wr_cnt++;
      end
      rd_pend = (rd_en === 1'b1);
      if (done === 1'b1) done_cnt++;
   end

   always @(posedge clk_50m) begin
      #1;
      if (rd_pend) begin
         rd_data = mem[rptr];
         rptr    = (rptr + 1) % TL;
         rd_cnt++;
      end
      wr_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      rd_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   task automatic start_run(input logic [1:0] m, input bit c);
      @(posedge clk_50m); #2;
      wptr = 0; rptr = 0; wr_cnt = 0; rd_cnt = 0; wr_bad = 0; done_cnt = 0;
      tb_mode = m; corrupt = c;
      mode = m; start = 1'b1;
      @(posedge clk_50m); #2;
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int cyc = 0;
      do begin @(negedge clk_50m); cyc++; end while (done !== 1'b1 && cyc < 8000);
      check({tag, "_done"}, done, 1);
      check({tag, "_busy_at_done"}, busy, 0);
      @(negedge clk_50m);
      check({tag, "_done_width"}, done, 0);
   endtask

   task automatic check_clean(input string tag);
      check({tag, "_pass_cnt"}, pass_cnt, 2);
      check({tag, "_err_count"}, err_count, 0);
      check({tag, "_error_flag"}, error_flag, 0);
      check({tag, "_wr_cnt"}, wr_cnt, 2 * TL);
      check({tag, "_rd_cnt"}, rd_cnt, 2 * TL);
      check({tag, "_wr_bad"}, wr_bad, 0);
      check({tag, "_done_cnt"}, done_cnt, 1);
   endtask

   initial begin
      logic [31:0] s;
      int c;
      s = 32'h1;
      for (int i = 0; i < TL; i++) begin
         lfsr_tab[i] = s;
         s = {1'b0, s[31:1]} ^ (s[0] ? 32'h8020_0003 : 32'h0);
      end
      rst_n = 1'b0; sdram_init_done = 1'b1; start = 1'b0; mode = 2'd0;
      wr_ready = 1'b1; rd_ready = 1'b1; rd_data = '0;
      repeat (3) @(negedge clk_50m);
      check("rst_busy", busy, 0);
      check("rst_wr_en", wr_en, 0);
      check("rst_rd_en", rd_en, 0);
      check("rst_done", done, 0);
      check("rst_err_count", err_count, 0);
      check("rst_pass_cnt", pass_cnt, 0);
      check("rst_first_err_addr", first_err_addr, 0);
      @(posedge clk_50m); #2 rst_n = 1'b1;

      // Incrementing data, two clean passes
      start_run(2'd0, 0);
      wait_done("incr");
      check_clean("incr");
      check("incr_word63", wlog[63], 16'h003F);

      // LFSR with both FIFOs throttled at random
      rand_rdy = 1;
      start_run(2'd3, 0);
      wait_done("lfsr");
      rand_rdy = 0;
      check_clean("lfsr");
      check("lfsr_word0", wlog[0], 16'h0001);
      check("lfsr_word1", wlog[1], 16'h0003);
      check("lfsr_word2", wlog[2], 16'h0002);

      // Inverted index
      start_run(2'd1, 0);
      wait_done("inv");
      check_clean("inv");
      check("inv_word2", wlog[2], 16'hFFFD);

      // Memory corrupts k=5 on both passes
      start_run(2'd0, 1);
      wait_done("corrupt");
      check("corrupt_err_count", err_count, 2);
      check("corrupt_error_flag", error_flag, 1);
      check("corrupt_first_addr", first_err_addr, 5);
      check("corrupt_first_exp", first_err_exp, 16'h0005);
      check("corrupt_first_got", first_err_got, 16'hDEAD);

      // start while busy is ignored
      start_run(2'd0, 0);
      c = 0;
      do begin @(negedge clk_50m); c++; end while (pass_cnt !== 4'd1 && c < 4000);
      check("busy_reach_pass1", pass_cnt, 1);
      @(posedge clk_50m); #2 start = 1'b1;
      @(posedge clk_50m); #2 start = 1'b0;
      @(negedge clk_50m);
      check("busy_start_ignored", pass_cnt, 1);
      wait_done("busy");
      check_clean("busy");

      // start with init_done low is ignored
      @(posedge clk_50m); #2 sdram_init_done = 1'b0; start = 1'b1;
      @(posedge clk_50m); #2 start = 1'b0;
      repeat (3) @(negedge clk_50m);
      check("noinit_busy", busy, 0);
      check("noinit_wr_cnt", wr_cnt, 2 * TL);
      @(posedge clk_50m); #2 sdram_init_done = 1'b1;

      // init_done drops mid-READ
      start_run(2'd0, 0);
      c = 0;
      do begin @(negedge clk_50m); c++; end while (rd_en !== 1'b1 && c < 4000);
      check("abort_reach_read", rd_en, 1);
      @(posedge clk_50m); #2 sdram_init_done = 1'b0;
      #1 check("abort_rd_en_drop", rd_en, 0);
      repeat (2) @(negedge clk_50m);
      check("abort_busy", busy, 0);
      repeat (5) @(negedge clk_50m);
      check("abort_no_done", done_cnt, 0);
      check("abort_pass_cnt", pass_cnt, 0);
      @(posedge clk_50m); #2 sdram_init_done = 1'b1;
      start_run(2'd0, 0);
      wait_done("rerun");
      check_clean("rerun");

`ifdef SDRAM_TEST_ERR_INJECT_EN
      // Walking-one with one injected flip at k=10
      inj_k = 10;
      start_run(2'd2, 0);
      c = 0;
      do begin @(negedge clk_50m); c++; end while (!(wr_en === 1'b1 && wr_data === 16'h0100) && c < 4000);
      check("inj_reach_k8", wr_data, 16'h0100);
      @(posedge clk_50m); #2 inj_err = 1'b1;
      @(posedge clk_50m); #2 inj_err = 1'b0;
      wait_done("inj");
      inj_k = -1;
      check("inj_wr_bad", wr_bad, 0);
      check("inj_err_count", err_count, 1);
      check("inj_first_addr", first_err_addr, 10);
      check("inj_first_exp", first_err_exp, 16'h0400);
      check("inj_first_got", first_err_got, 16'h0401);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
